// File: rtl/conv_stream_pkg.sv
// Shared types and sizing helpers for the conv output streamer.
// Optional ReLU on the output path is enabled by defining CONV_STREAM_RELU_EN.
package conv_stream_pkg;

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_e;

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_H_OUT = 28;
    localparam int DEF_W_OUT = 28;
    localparam int N_ELEM    = DEF_H_OUT * DEF_W_OUT;
    localparam int ROW_W     = cnt_w(DEF_H_OUT);
    localparam int COL_W     = cnt_w(DEF_W_OUT);

endpackage

// File: rtl/relu_fp32.sv
// Combinational ReLU for IEEE-754 words: any word with the sign bit set
// (including -0.0) becomes +0.0, all others pass unchanged.
module relu_fp32 #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    assign data_o = data_i[DATA_WIDTH-1] ? '0 : data_i;

endmodule

// File: rtl/conv_output_streamer.sv
// Captures a whole conv feature map on start and streams it row-major over
// valid/ready with row/frame markers. Define CONV_STREAM_RELU_EN for output ReLU.
module conv_output_streamer
    import conv_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int H_OUT      = DEF_H_OUT,
    parameter int W_OUT      = DEF_W_OUT
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [H_OUT*W_OUT*DATA_WIDTH-1:0] featureMap,
    input  logic                              start,
    output logic                              busy,
    output logic [DATA_WIDTH-1:0]             outData,
    output logic                              outValid,
    input  logic                              outReady,
    output logic                              outRowLast,
    output logic                              outFrameLast,
    output logic                              done
);

    localparam int NE = H_OUT * W_OUT;
    localparam int RW = cnt_w(H_OUT);
    localparam int CW = cnt_w(W_OUT);
    localparam int KW = cnt_w(NE);

    state_e                      state_q, state_d;
    logic [RW-1:0]               row_q, row_d;
    logic [CW-1:0]               col_q, col_d;
    logic                        done_q;
    logic [NE*DATA_WIDTH-1:0]    map_q;
    logic [DATA_WIDTH-1:0]       elems [NE];
    logic [KW-1:0]               idx;
    logic [DATA_WIDTH-1:0]       elem;
    logic [DATA_WIDTH-1:0]       elem_out;
    logic                        last_col;
    logic                        last_row;

    assign last_col = (col_q == CW'(W_OUT - 1));
    assign last_row = (row_q == RW'(H_OUT - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            done_q  <= (state_q == DONE);
        end
    end

    // Capture register is deliberately left out of reset; only a start in IDLE loads it.
    always_ff @(posedge clk) begin
        if (reset && (state_q == IDLE) && start) begin
            map_q <= featureMap;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = STREAM;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            STREAM: begin
                if (outReady) begin
                    if (last_col) begin
                        col_d = '0;
                        if (last_row) begin
                            row_d   = '0;
                            state_d = DONE;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    for (genvar k = 0; k < NE; k++) begin : g_elem
        assign elems[k] = map_q[k*DATA_WIDTH +: DATA_WIDTH];
    end

    assign idx  = KW'(row_q) * KW'(W_OUT) + KW'(col_q);
    assign elem = elems[idx];

`ifdef CONV_STREAM_RELU_EN
    relu_fp32 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_relu (
        .data_i (elem),
        .data_o (elem_out)
    );
`else
    assign elem_out = elem;
`endif

    always_comb begin
        outValid     = (state_q == STREAM);
        busy         = (state_q == STREAM);
        outData      = outValid ? elem_out : '0;
        outRowLast   = outValid && last_col;
        outFrameLast = outValid && last_col && last_row;
        done         = done_q;
    end

endmodule

// File: tb/tb_conv_output_streamer.sv
// Scoreboard bench for conv_output_streamer on a 4x4 map; honours CONV_STREAM_RELU_EN.
module tb_conv_output_streamer;

    localparam int DW = 32;
    localparam int H  = 4;
    localparam int W  = 4;
    localparam int N  = H * W;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            outReady;
    logic [N*DW-1:0] featureMap;
    logic            busy;
    logic [DW-1:0]   outData;
    logic            outValid;
    logic            outRowLast;
    logic            outFrameLast;
    logic            done;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          rl;
        logic          fl;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] words [N];
    int            n_checks = 0;
    int            n_err    = 0;
    int            done_cnt = 0;
    int            hs_cnt   = 0;
    logic          bp_en    = 1'b0;
    logic          rdy_force = 1'b1;

    always #5 clk = ~clk;

    conv_output_streamer #(
        .DATA_WIDTH (DW),
        .H_OUT      (H),
        .W_OUT      (W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .featureMap   (featureMap),
        .start        (start),
        .busy         (busy),
        .outData      (outData),
        .outValid     (outValid),
        .outReady     (outReady),
        .outRowLast   (outRowLast),
        .outFrameLast (outFrameLast),
        .done         (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] model(input logic [DW-1:0] w);
`ifdef CONV_STREAM_RELU_EN
        return w[DW-1] ? '0 : w;
`else
        return w;
`endif
    endfunction

    // Called at posedge+1; returns at posedge+1 just after the capture edge.
    task automatic start_frame();
        exp_t e;
        for (int k = 0; k < N; k++) begin
            featureMap[k*DW +: DW] = words[k];
            e.data = model(words[k]);
            e.rl   = (k % W) == (W - 1);
            e.fl   = (k == N - 1);
            sb.push_back(e);
        end
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // outReady driver: pattern 1,0,0 under backpressure, otherwise forced level.
    initial begin
        int bp_i;
        bp_i = 0;
        outReady = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) begin
                outReady = (bp_i % 3 == 0);
                bp_i++;
            end else begin
                outReady = rdy_force;
                bp_i = 0;
            end
        end
    end

    // Output monitor: scoreboard pops on handshake, stability while stalled.
    initial begin
        logic          stall;
        logic [DW-1:0] h_data;
        logic          h_rl, h_fl;
        exp_t          e;
        stall = 1'b0;
        h_data = '0;
        h_rl = 1'b0;
        h_fl = 1'b0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                if (!outValid) begin
                    check("markers_idle", {30'd0, outRowLast, outFrameLast}, 32'd0);
                end
                if (outValid && stall) begin
                    check("hold_data", outData, h_data);
                    check("hold_rl", 32'(outRowLast), 32'(h_rl));
                    check("hold_fl", 32'(outFrameLast), 32'(h_fl));
                end
                if (outValid && outReady) begin
                    hs_cnt++;
                    if (sb.size() == 0) begin
                        check("extra_word", outData, 32'hxxxxxxxx);
                    end else begin
                        e = sb.pop_front();
                        check("data", outData, e.data);
                        check("rowlast", 32'(outRowLast), 32'(e.rl));
                        check("framelast", 32'(outFrameLast), 32'(e.fl));
                    end
                end
                stall  = outValid && !outReady;
                h_data = outData;
                h_rl   = outRowLast;
                h_fl   = outFrameLast;
                if (done) done_cnt++;
            end else begin
                stall = 1'b0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int d0;
        reset      = 1'b0;
        start      = 1'b1;
        featureMap = '0;

        // Reset held with start asserted
        repeat (3) begin
            @(negedge clk);
            check("rst_valid", 32'(outValid), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
        end
        @(posedge clk);
        #1 start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("idle_valid", 32'(outValid), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_data", outData, 32'd0);

        // Basic stream with cycle-exact completion timing
        for (int k = 0; k < N; k++) words[k] = 32'h3F800000 + 32'(k);
        @(posedge clk);
        #1 start_frame();
        for (int n = 1; n <= 19; n++) begin
            @(negedge clk);
            if (n == 1)  check("first_valid", 32'(outValid), 32'd1);
            if (n <= 16) check("busy_stream", 32'(busy), 32'd1);
            if (n == 17) begin
                check("busy_low", 32'(busy), 32'd0);
                check("valid_low", 32'(outValid), 32'd0);
                check("done_early", 32'(done), 32'd0);
            end
            if (n == 18) check("done_pulse", 32'(done), 32'd1);
            if (n == 19) check("done_once", 32'(done), 32'd0);
        end
        check("sb_empty_basic", 32'(sb.size()), 32'd0);

        // Backpressure
        for (int k = 0; k < N; k++) words[k] = $urandom;
        @(posedge clk);
        bp_en = 1'b1;
        #1 start_frame();
        wait_done(400);
        bp_en = 1'b0;
        check("sb_empty_bp", 32'(sb.size()), 32'd0);

        // Capture isolation: map changes after capture, start pulsed mid-frame
        for (int k = 0; k < N; k++) words[k] = $urandom;
        d0 = done_cnt;
        start_frame();
        featureMap = '1;
        repeat (4) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(100);
        repeat (4) begin
            @(negedge clk);
            check("no_second_frame", 32'(outValid), 32'd0);
        end
        check("done_count_iso", 32'(done_cnt - d0), 32'd1);
        check("sb_empty_iso", 32'(sb.size()), 32'd0);

        // Abort after the 5th handshake
        for (int k = 0; k < N; k++) words[k] = 32'h40000000 + 32'(k * 3);
        @(posedge clk);
        #1 start_frame();
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort_hs", 32'(hs_cnt % N), 32'd5);
        @(negedge clk);
        check("abort_valid", 32'(outValid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        sb.delete();
        d0 = done_cnt;
        repeat (20) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        @(posedge clk);
        #1 start_frame();
        wait_done(100);
        check("sb_empty_replay", 32'(sb.size()), 32'd0);

        // Sign-bit words for the ReLU path
        for (int k = 0; k < N; k++) words[k] = $urandom;
        words[0] = 32'h40490FDB;
        words[2] = 32'hC0000000;
        words[3] = 32'h80000000;
        start_frame();
        wait_done(100);
        check("sb_empty_relu", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
